mem_access_unit: RTL and testbench

// Memory-stage load/store unit. Consumes the execute-stage results after the E/M register:

---
 rtl/mem_access_unit.sv | 221 ++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage load/store unit.
// Runs a request/grant/response handshake to data memory, lays out store data on the
// byte lanes, and returns sign/zero-extended load data.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned half/word accesses
// without touching the bus. Otherwise the offending low address bits are ignored.
module mem_access_unit #(
    parameter int unsigned MAX_WAIT = 255,  // cycles allowed in REQ or WAIT before timeout
    parameter int unsigned WAIT_W   = 8     // timeout counter width, must hold MAX_WAIT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemWriteM,
    input  logic        LoadEnM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [1:0]  StoreSrcM,
    input  logic [2:0]  LoadSrcM,
    output logic        DReq,
    output logic        DWe,
    output logic [31:0] DAddr,
    output logic [31:0] DWData,
    output logic [3:0]  DBe,
    input  logic        DGnt,
    input  logic        DRValid,
    input  logic [31:0] DRData,
    output logic [31:0] ReadDataM,
    output logic        ReadValidM,
    output logic        StallM,
    output logic        BusErrM
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LHU = 3'b010;
    localparam logic [2:0] LD_LB  = 3'b011;
    localparam logic [2:0] LD_LBU = 3'b100;

    localparam logic [1:0] ST_SH = 2'b01;
    localparam logic [1:0] ST_SB = 2'b10;

    state_t state, state_nx;

    logic              access;
    logic              misalign;
    logic              timeout;
    logic [WAIT_W-1:0] cnt_r;

    // Request captured on leaving IDLE.
    logic [31:2] addr_r;
    logic [31:0] wdata_r;
    logic [3:0]  be_r;
    logic        st_r;
    logic [2:0]  ld_type_r;
    logic [1:0]  off_r;
    logic        err_r;
    logic [31:0] rdata_r;

    logic [31:0] st_wdata;
    logic [3:0]  st_be;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] ld_ext;

    // A store takes priority when both strobes are set.
    assign access  = MemWriteM | LoadEnM;
    assign timeout = (cnt_r == WAIT_W'(MAX_WAIT - 1));

    // Lay out store data and byte enables for the current M-stage store.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        st_wdata = WriteDataM;
        st_be    = 4'b1111;
        case (StoreSrcM)
            ST_SB: begin
                st_wdata = {4{WriteDataM[7:0]}};
                st_be    = 4'b0001 << ALUResultM[1:0];
            end
            ST_SH: begin
                st_wdata = {2{WriteDataM[15:0]}};
                st_be    = ALUResultM[1] ? 4'b1100 : 4'b0011;
            end
            default: ;  // sw and the reserved encoding move the whole word
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    // Flag half accesses on odd bytes and word accesses off a word boundary.
    always_comb begin
        misalign = 1'b0;
        if (MemWriteM) begin
            case (StoreSrcM)
                ST_SH:   misalign = ALUResultM[0];
                ST_SB:   misalign = 1'b0;
                default: misalign = |ALUResultM[1:0];
            endcase
        end else begin
            case (LoadSrcM)
                LD_LH, LD_LHU: misalign = ALUResultM[0];
                LD_LB, LD_LBU: misalign = 1'b0;
                default:       misalign = |ALUResultM[1:0];
            endcase
        end
    end
`else
    assign misalign = 1'b0;
`endif

    // Pick the addressed lane out of the returned word and extend it.
    always_comb begin
        case (off_r)
            2'd0:    lane_b = DRData[7:0];
            2'd1:    lane_b = DRData[15:8];
            2'd2:    lane_b = DRData[23:16];
            default: lane_b = DRData[31:24];
        endcase
        lane_h = off_r[1] ? DRData[31:16] : DRData[15:0];
        case (ld_type_r)
            LD_LH:   ld_ext = {{16{lane_h[15]}}, lane_h};
            LD_LHU:  ld_ext = {16'h0000, lane_h};
            LD_LB:   ld_ext = {{24{lane_b[7]}}, lane_b};
            LD_LBU:  ld_ext = {24'h000000, lane_b};
            default: ld_ext = DRData;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next-state logic; grant/valid win over a timeout in the same cycle.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (access) state_nx = misalign ? S_DONE : S_REQ;
            S_REQ: begin
                if (DGnt)         state_nx = st_r ? S_DONE : S_WAIT;
                else if (timeout) state_nx = S_DONE;
            end
            S_WAIT: if (DRValid || timeout) state_nx = S_DONE;
            default: state_nx = S_IDLE;  // DONE never re-examines the held M-stage instruction
        endcase
    end

    // Bus and pipeline outputs decoded from the current state.
    always_comb begin
        DReq       = 1'b0;
        DWe        = 1'b0;
        DAddr      = 32'h0;
        DWData     = 32'h0;
        DBe        = 4'h0;
        StallM     = 1'b0;
        ReadValidM = 1'b0;
        BusErrM    = 1'b0;
        case (state)
            // Gated by reset so a held M-stage access cannot freeze the pipe during reset.
            S_IDLE: StallM = access & rst_n;
            S_REQ: begin
                DReq   = 1'b1;
                DWe    = st_r;
                DAddr  = {addr_r, 2'b00};
                DWData = wdata_r;
                DBe    = be_r;
                StallM = 1'b1;
            end
            S_WAIT: StallM = 1'b1;
            default: begin
                ReadValidM = ~st_r & ~err_r;
                BusErrM    = err_r;
            end
        endcase
    end

    // Timeout counter: restarts on every state change, counts while in REQ or WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                  cnt_r <= '0;
        else if (state_nx != state)                  cnt_r <= '0;
        else if (state == S_REQ || state == S_WAIT)  cnt_r <= cnt_r + WAIT_W'(1);
    end

    // Capture the request on leaving IDLE and record how the access ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r    <= '0;
            wdata_r   <= '0;
            be_r      <= '0;
            st_r      <= 1'b0;
            ld_type_r <= '0;
            off_r     <= '0;
            err_r     <= 1'b0;
        end else if (state == S_IDLE && access) begin
            addr_r    <= ALUResultM[31:2];
            wdata_r   <= MemWriteM ? st_wdata : 32'h0;
            be_r      <= MemWriteM ? st_be : 4'b1111;  // loads read the whole word
            st_r      <= MemWriteM;
            ld_type_r <= LoadSrcM;
            off_r     <= ALUResultM[1:0];
            err_r     <= misalign;
        end else if ((state == S_REQ && !DGnt && timeout) ||
                     (state == S_WAIT && !DRValid && timeout)) begin
            err_r <= 1'b1;
        end
    end

    // Load result register; holds its value until the next successful load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           rdata_r <= '0;
        else if (state == S_WAIT && DRValid)  rdata_r <= ld_ext;
    end

    assign ReadDataM = rdata_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: self-checking bench for mem_access_unit.
// A transaction-level model predicts cycle counts, bus fields, completion pulses and
// load results from the access rules; directed vectors, random transactions and a
// reset-abort sequence are compared against it.
module tb_mem_access_unit;

    localparam int MAX_WAIT = 4;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemWriteM, LoadEnM;
    logic [31:0] ALUResultM, WriteDataM;
    logic [1:0]  StoreSrcM;
    logic [2:0]  LoadSrcM;
    logic        DReq, DWe;
    logic [31:0] DAddr, DWData;
    logic [3:0]  DBe;
    logic        DGnt, DRValid;
    logic [31:0] DRData;
    logic [31:0] ReadDataM;
    logic        ReadValidM, StallM, BusErrM;

    mem_access_unit #(.MAX_WAIT(MAX_WAIT), .WAIT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .MemWriteM(MemWriteM), .LoadEnM(LoadEnM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .StoreSrcM(StoreSrcM), .LoadSrcM(LoadSrcM),
        .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWData(DWData), .DBe(DBe),
        .DGnt(DGnt), .DRValid(DRValid), .DRData(DRData),
        .ReadDataM(ReadDataM), .ReadValidM(ReadValidM),
        .StallM(StallM), .BusErrM(BusErrM)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        ld;
        logic [1:0]  st;
        logic [2:0]  lt;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] word;
        int          gnt_dly;  // REQ cycles without grant before DGnt
        int          rv_dly;   // WAIT cycles without data before DRValid
    } txn_t;

    typedef struct {
        txn_t        t;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_be;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_stall;
    } vec_t;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_rd   = 32'h0;
    vec_t        vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int acc_size(input logic st, input logic [1:0] stype, input logic [2:0] lt);
        if (st) return (stype == 2'd2) ? 1 : (stype == 2'd1) ? 2 : 4;
        return (lt == 3'd3 || lt == 3'd4) ? 1 : (lt == 3'd1 || lt == 3'd2) ? 2 : 4;
    endfunction

    function automatic logic misaligned(input logic st, input logic [1:0] stype,
                                        input logic [2:0] lt, input logic [31:0] a);
        int sz;
        sz = acc_size(st, stype, lt);
        return TRAP && ((a % sz) != 0);
    endfunction

    function automatic void store_model(input logic [1:0] stype, input logic [31:0] a,
                                        input logic [31:0] d, output logic [31:0] wd,
                                        output logic [3:0] be);
        int sz;
        sz = acc_size(1'b1, stype, 3'd0);
        if (sz == 1) begin
            wd = (d & 32'hFF) * 32'h01010101;
            be = 4'(1 << (a % 4));
        end else if (sz == 2) begin
            wd = (d & 32'hFFFF) * 32'h00010001;
            be = (((a / 2) % 2) == 1) ? 4'b1100 : 4'b0011;
        end else begin
            wd = d;
            be = 4'b1111;
        end
    endfunction

    function automatic logic [31:0] load_model(input logic [2:0] lt, input logic [31:0] a,
                                               input logic [31:0] w);
        logic [31:0] v;
        if (lt == 3'd3 || lt == 3'd4) begin
            v = (w >> (8 * (a % 4))) & 32'hFF;
            if (lt == 3'd3 && v >= 32'd128) v = v - 32'd256;
        end else if (lt == 3'd1 || lt == 3'd2) begin
            v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
            if (lt == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic txn_t mk(input logic we, input logic ld, input logic [1:0] st,
                                input logic [2:0] lt, input logic [31:0] addr,
                                input logic [31:0] data, input logic [31:0] word,
                                input int gd, input int rd);
        txn_t t;
        t.we = we; t.ld = ld; t.st = st; t.lt = lt; t.addr = addr;
        t.data = data; t.word = word; t.gnt_dly = gd; t.rv_dly = rd;
        return t;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " DReq"}, {31'h0, DReq}, 32'h0);
        check({tag, " DWe"}, {31'h0, DWe}, 32'h0);
        check({tag, " DAddr"}, DAddr, 32'h0);
        check({tag, " DWData"}, DWData, 32'h0);
        check({tag, " DBe"}, {28'h0, DBe}, 32'h0);
        check({tag, " ReadDataM"}, ReadDataM, 32'h0);
        check({tag, " ReadValidM"}, {31'h0, ReadValidM}, 32'h0);
        check({tag, " StallM"}, {31'h0, StallM}, 32'h0);
        check({tag, " BusErrM"}, {31'h0, BusErrM}, 32'h0);
    endtask

    // Drive one M-stage instruction from IDLE through DONE, playing the memory side and
    // checking every cycle against the model. Bus strobes outside their window are noise.
    task automatic run_txn(input txn_t t, output logic [31:0] o_wdata, output logic [3:0] o_be,
                           output logic [31:0] o_rd, output logic o_err, output int o_stall);
        logic        acc, st, trap, gnt_ok, rv_ok, err, rvalid;
        logic        in_req, in_wait, in_done;
        int          nreq, nwait, total, k, j;
        logic [31:0] m_wdata;
        logic [3:0]  m_be;
        acc    = t.we | t.ld;
        st     = t.we;
        trap   = acc && misaligned(st, t.st, t.lt, t.addr);
        gnt_ok = t.gnt_dly < MAX_WAIT;
        rv_ok  = t.rv_dly < MAX_WAIT;
        nreq   = trap ? 0 : (gnt_ok ? t.gnt_dly + 1 : MAX_WAIT);
        nwait  = (trap || st || !gnt_ok) ? 0 : (rv_ok ? t.rv_dly + 1 : MAX_WAIT);
        err    = trap || !gnt_ok || (nwait > 0 && !rv_ok);
        rvalid = !st && !err;
        store_model(t.st, t.addr, t.data, m_wdata, m_be);
        total  = acc ? 2 + nreq + nwait : 1;
        o_wdata = 32'h0; o_be = 4'h0; o_rd = 32'h0; o_err = 1'b0; o_stall = 0;
        for (int c = 0; c < total; c++) begin
            k       = c - 1;
            j       = c - 1 - nreq;
            in_req  = acc && c >= 1 && c < 1 + nreq;
            in_wait = acc && c >= 1 + nreq && c < 1 + nreq + nwait;
            in_done = acc && c == total - 1;
            MemWriteM  = t.we;    LoadEnM   = t.ld;
            ALUResultM = t.addr;  WriteDataM = t.data;
            StoreSrcM  = t.st;    LoadSrcM  = t.lt;
            DGnt       = in_req  ? (k == t.gnt_dly) : 1'($urandom % 2);
            DRValid    = in_wait ? (j == t.rv_dly)  : 1'($urandom % 2);
            DRData     = (in_wait && j == t.rv_dly) ? t.word : $urandom;
            @(negedge clk);
            check("DReq", {31'h0, DReq}, {31'h0, in_req});
            check("StallM", {31'h0, StallM}, {31'h0, acc && !in_done});
            if (StallM) o_stall++;
            if (in_req) begin
                check("DWe", {31'h0, DWe}, {31'h0, st});
                check("DAddr", DAddr, t.addr & 32'hFFFF_FFFC);
                if (st) begin
                    check("DWData", DWData, m_wdata);
                    check("DBe", {28'h0, DBe}, {28'h0, m_be});
                end
                if (k == 0) begin
                    o_wdata = DWData;
                    o_be    = DBe;
                end
            end
            check("ReadValidM", {31'h0, ReadValidM}, {31'h0, in_done && rvalid});
            check("BusErrM", {31'h0, BusErrM}, {31'h0, in_done && err});
            if (in_done && rvalid) exp_rd = load_model(t.lt, t.addr, t.word);
            check("ReadDataM", ReadDataM, exp_rd);
            if (in_done) begin
                o_rd  = ReadDataM;
                o_err = BusErrM;
            end
            step();
        end
        MemWriteM = 1'b0; LoadEnM = 1'b0; DGnt = 1'b0; DRValid = 1'b0;
    endtask

    initial begin
        logic [31:0] o_wdata, o_rd;
        logic [3:0]  o_be;
        logic        o_err;
        int          o_stall;
        txn_t        t;

        // Directed vectors: {txn, DWData, DBe, ReadDataM, BusErrM, stall cycles}.
        vecs[0]  = '{mk(1, 0, 2'b00, 3'd0, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0),
                     32'hDEADBEEF, 4'b1111, 32'h0, 1'b0, 2};
        vecs[1]  = '{mk(1, 0, 2'b10, 3'd0, 32'h103, 32'h000000A5, 32'h0, 0, 0),
                     32'hA5A5A5A5, 4'b1000, 32'h0, 1'b0, 2};
        vecs[2]  = '{mk(0, 1, 2'b00, 3'd3, 32'h101, 32'h0, 32'h12348056, 0, 0),
                     32'h0, 4'h0, 32'hFFFFFF80, 1'b0, 3};
        vecs[3]  = '{mk(0, 1, 2'b00, 3'd4, 32'h101, 32'h0, 32'h12348056, 0, 0),
                     32'h0, 4'h0, 32'h00000080, 1'b0, 3};
        vecs[4]  = '{mk(0, 1, 2'b00, 3'd1, 32'h102, 32'h0, 32'h9ABC0000, 3, 1),
                     32'h0, 4'h0, 32'hFFFF9ABC, 1'b0, 7};
        vecs[5]  = '{mk(0, 1, 2'b00, 3'd0, 32'h200, 32'h0, 32'h11111111, 99, 0),
                     32'h0, 4'h0, 32'hFFFF9ABC, 1'b1, 5};
        vecs[6]  = '{mk(1, 0, 2'b01, 3'd0, 32'h101, 32'h1234ABCD, 32'h0, 1, 0),
                     32'hABCDABCD, 4'b0011, 32'hFFFF9ABC, TRAP, TRAP ? 1 : 3};
        vecs[7]  = '{mk(0, 1, 2'b00, 3'd0, 32'h102, 32'h0, 32'hCAFEF00D, 0, 0),
                     32'h0, 4'h0, TRAP ? 32'hFFFF9ABC : 32'hCAFEF00D, TRAP, TRAP ? 1 : 3};
        vecs[8]  = '{mk(0, 1, 2'b00, 3'd0, 32'h300, 32'h0, 32'h55555555, 0, 99),
                     32'h0, 4'h0, TRAP ? 32'hFFFF9ABC : 32'hCAFEF00D, 1'b1, 6};
        vecs[9]  = '{mk(1, 1, 2'b00, 3'd0, 32'h404, 32'h11223344, 32'h66666666, 0, 0),
                     32'h11223344, 4'b1111, TRAP ? 32'hFFFF9ABC : 32'hCAFEF00D, 1'b0, 2};
        vecs[10] = '{mk(0, 1, 2'b00, 3'd2, 32'h106, 32'h0, 32'h80017FFF, 0, 0),
                     32'h0, 4'h0, 32'h00008001, 1'b0, 3};

        // Reset with an access pending: everything must read zero.
        rst_n = 1'b0;
        MemWriteM = 1'b1; LoadEnM = 1'b1; ALUResultM = 32'h104; WriteDataM = 32'h12345678;
        StoreSrcM = 2'b00; LoadSrcM = 3'd0; DGnt = 1'b1; DRValid = 1'b1; DRData = 32'hFFFFFFFF;
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");
        step();
        rst_n = 1'b1;
        MemWriteM = 1'b0; LoadEnM = 1'b0; DGnt = 1'b0; DRValid = 1'b0;
        step();

        for (int i = 0; i < 11; i++) begin
            run_txn(vecs[i].t, o_wdata, o_be, o_rd, o_err, o_stall);
            check($sformatf("vec%0d BusErrM", i), {31'h0, o_err}, {31'h0, vecs[i].exp_err});
            check($sformatf("vec%0d ReadDataM", i), o_rd, vecs[i].exp_rd);
            check($sformatf("vec%0d stall cycles", i), o_stall, vecs[i].exp_stall);
            if (vecs[i].t.we && !vecs[i].exp_err) begin
                check($sformatf("vec%0d DWData", i), o_wdata, vecs[i].exp_wdata);
                check($sformatf("vec%0d DBe", i), {28'h0, o_be}, {28'h0, vecs[i].exp_be});
            end
        end

        // Random traffic, including idle slots, dual strobes, misalignment and timeouts.
        for (int i = 0; i < 200; i++) begin
            t = mk(1'($urandom % 3 == 0), 1'($urandom % 2), 2'($urandom), 3'($urandom),
                   $urandom, $urandom, $urandom,
                   int'($urandom_range(0, MAX_WAIT + 1)), int'($urandom_range(0, MAX_WAIT + 1)));
            run_txn(t, o_wdata, o_be, o_rd, o_err, o_stall);
        end

        // Reset during WAIT aborts the load; a late DRValid must not complete anything.
        t = mk(0, 1, 2'b00, 3'd0, 32'h500, 32'h0, 32'h0, 0, 0);
        MemWriteM = 1'b0; LoadEnM = 1'b1; ALUResultM = t.addr; LoadSrcM = 3'd0;
        DGnt = 1'b0; DRValid = 1'b0;
        step();
        DGnt = 1'b1;
        @(negedge clk);
        check("abort REQ DReq", {31'h0, DReq}, 32'h1);
        step();
        DGnt = 1'b0;
        @(negedge clk);
        check("abort WAIT StallM", {31'h0, StallM}, 32'h1);
        check("abort WAIT DReq", {31'h0, DReq}, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        exp_rd = 32'h0;
        check_all_zero("abort");
        step();
        rst_n = 1'b1; LoadEnM = 1'b0; DRValid = 1'b1; DRData = 32'hFFFFFFFF;
        @(negedge clk);
        check("late DRValid ReadValidM", {31'h0, ReadValidM}, 32'h0);
        check("late DRValid StallM", {31'h0, StallM}, 32'h0);
        check("late DRValid DReq", {31'h0, DReq}, 32'h0);
        step();
        DRValid = 1'b0;
        @(negedge clk);
        check("late DRValid ReadDataM", ReadDataM, exp_rd);
        check("late DRValid BusErrM", {31'h0, BusErrM}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
